token_emitter: RTL and testbench

Token emitter at the tail of the execute pipeline: accepts one execution result per handshake (data plus true/false next-node destinations, as produced by the execute stage) and turns it into zero, one or two outgoing tokens on a valid/ready token port feeding back toward the decode/matching side. It buffers results in a small FIFO so the execute stage is stalled only when the buffer fills. It applies the branch/copy/terminate rules and signals termination.

---
 rtl/temit_pkg.sv | 52 +++++
 rtl/temit_fifo.sv | 59 +++++
 rtl/token_emitter.sv | 187 ++++++++++++++++++
 tb/tb_token_emitter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/temit_pkg.sv
// Shared types for the token emitter: buffered result record, FSM state
// encoding, null-node constant and the per-result routing decision.
package temit_pkg;

  localparam int unsigned TEMIT_DATA_W = 32;
  localparam int unsigned TEMIT_NODE_W = 16;
  localparam int unsigned TEMIT_GEN_W  = 12;
  localparam int unsigned TOK_CNT_W    = 16;

  // A destination node of zero means "no token on this path".
  localparam logic [TEMIT_NODE_W-1:0] NULL_NODE = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_T = 2'd1,
    EMIT_F = 2'd2,
    TERM   = 2'd3
  } state_t;

  // One execution result as buffered in the FIFO.
  typedef struct packed {
    logic [TEMIT_DATA_W-1:0] data;
    logic [TEMIT_GEN_W-1:0]  gen;
    logic                    cond;
    logic                    cp;
    logic                    terminate;
    logic [TEMIT_NODE_W-1:0] t_node;
    logic                    t_lr;
    logic                    t_uni_opr;
    logic [TEMIT_NODE_W-1:0] f_node;
    logic                    f_lr;
    logic                    f_uni_opr;
  } result_t;

  // First action for a fresh head entry; IDLE means retire with no token.
  function automatic state_t decide(input result_t r);
    state_t s;
    s = IDLE;
    if (r.terminate) begin
      s = TERM;
    end else if (r.cp) begin
      if (r.t_node != NULL_NODE)      s = EMIT_T;
      else if (r.f_node != NULL_NODE) s = EMIT_F;
    end else if (r.cond) begin
      if (r.t_node != NULL_NODE)      s = EMIT_T;
    end else begin
      if (r.f_node != NULL_NODE)      s = EMIT_F;
    end
    return s;
  endfunction

endpackage

// File: rtl/temit_fifo.sv
// Synchronous FIFO buffering execution results ahead of the emitter FSM.
// Ports: clk, rst (sync, active-high); push/wdata write side; pop/rdata
// read side (rdata shows the head entry); count, full, empty status.
// Pushes while full and pops while empty are ignored.
module temit_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/token_emitter.sv
// Token emitter at the tail of the execute pipeline. Buffers execution
// results and turns each into zero, one or two tokens (branch / copy /
// terminate rules), with a one-cycle terminate pulse and a token counter.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready + fields   result input handshake (data, cond, cp,
//                                terminate, gen, t/f node, lr, uni_opr)
//   tok_valid/tok_ready + fields token output handshake (node, gen, data,
//                                lr, uni_opr, last)
//   term_o_temit                 terminate pulse
//   busy_o_temit                 result buffer non-empty
//   tok_cnt_o_temit              accepted-token counter (wraps)
// The buffered record layout comes from temit_pkg; the width parameters
// default to the package widths and are expected to match them.
module token_emitter
  import temit_pkg::*;
#(
  parameter int unsigned DATA_W = TEMIT_DATA_W,
  parameter int unsigned NODE_W = TEMIT_NODE_W,
  parameter int unsigned GEN_W  = TEMIT_GEN_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i_temit,
  output logic                 in_ready_o_temit,
  input  logic [DATA_W-1:0]    data_i_temit,
  input  logic                 cond_i_temit,
  input  logic                 cp_i_temit,
  input  logic                 terminate_i_temit,
  input  logic [GEN_W-1:0]     gen_i_temit,
  input  logic [NODE_W-1:0]    t_next_node_i_temit,
  input  logic [NODE_W-1:0]    f_next_node_i_temit,
  input  logic                 t_next_lr_i_temit,
  input  logic                 f_next_lr_i_temit,
  input  logic                 t_next_uni_opr_i_temit,
  input  logic                 f_next_uni_opr_i_temit,
  output logic                 tok_valid_o_temit,
  input  logic                 tok_ready_i_temit,
  output logic [NODE_W-1:0]    tok_node_o_temit,
  output logic [GEN_W-1:0]     tok_gen_o_temit,
  output logic [DATA_W-1:0]    tok_data_o_temit,
  output logic                 tok_lr_o_temit,
  output logic                 tok_uni_opr_o_temit,
  output logic                 tok_last_o_temit,
  output logic                 term_o_temit,
  output logic                 busy_o_temit,
  output logic [TOK_CNT_W-1:0] tok_cnt_o_temit
);

  localparam int unsigned RES_W = $bits(result_t);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  result_t              in_res;
  result_t              head;
  logic [RES_W-1:0]     head_bits;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  state_t               state_q;
  state_t               cur_state;
  state_t               next_state;
  logic                 tok_valid;
  logic                 tok_last;
  logic                 sel_f;
  logic                 term_c;
  logic                 term_q;
  logic [TOK_CNT_W-1:0] tok_cnt_q;

  // Pack the incoming result into the buffered record.
  always_comb begin
    in_res           = '0;
    in_res.data      = data_i_temit;
    in_res.gen       = gen_i_temit;
    in_res.cond      = cond_i_temit;
    in_res.cp        = cp_i_temit;
    in_res.terminate = terminate_i_temit;
    in_res.t_node    = t_next_node_i_temit;
    in_res.t_lr      = t_next_lr_i_temit;
    in_res.t_uni_opr = t_next_uni_opr_i_temit;
    in_res.f_node    = f_next_node_i_temit;
    in_res.f_lr      = f_next_lr_i_temit;
    in_res.f_uni_opr = f_next_uni_opr_i_temit;
  end

  // Ready depends only on reset and the registered fill level.
  assign in_ready_o_temit = !rst && !fifo_full;
  assign push             = in_valid_i_temit && in_ready_o_temit;

  temit_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_res),
    .pop   (pop),
    .rdata (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = head_bits;

  // State register, terminate pulse and token counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      term_q    <= 1'b0;
      tok_cnt_q <= '0;
    end else begin
      state_q <= next_state;
      term_q  <= term_c;
      if (tok_valid && tok_ready_i_temit) tok_cnt_q <= tok_cnt_q + TOK_CNT_W'(1);
    end
  end

  // Next-state and handshake logic. In IDLE the head entry is decoded in
  // the same cycle, so a fresh result starts emitting (or retires) without
  // an extra bubble; a stalled token parks the FSM in its EMIT state.
  always_comb begin
    cur_state  = state_q;
    next_state = state_q;
    pop        = 1'b0;
    tok_valid  = 1'b0;
    tok_last   = 1'b0;
    sel_f      = 1'b0;
    term_c     = 1'b0;
    if (state_q == IDLE && !fifo_empty) cur_state = decide(head);
    case (cur_state)
      IDLE: begin
        // Non-empty here means both selected destinations are null.
        pop        = !fifo_empty;
        next_state = IDLE;
      end
      TERM: begin
        pop        = 1'b1;
        term_c     = 1'b1;
        next_state = IDLE;
      end
      EMIT_T: begin
        tok_valid = 1'b1;
        tok_last  = !(head.cp && head.f_node != NULL_NODE);
        if (tok_ready_i_temit) begin
          if (tok_last) begin
            pop        = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = EMIT_F;
          end
        end else begin
          next_state = EMIT_T;
        end
      end
      EMIT_F: begin
        tok_valid = 1'b1;
        tok_last  = 1'b1;
        sel_f     = 1'b1;
        if (tok_ready_i_temit) begin
          pop        = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = EMIT_F;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Token fields are forced to zero whenever no token is offered.
  assign tok_valid_o_temit   = tok_valid;
  assign tok_node_o_temit    = !tok_valid ? '0 : (sel_f ? head.f_node : head.t_node);
  assign tok_lr_o_temit      = tok_valid && (sel_f ? head.f_lr : head.t_lr);
  assign tok_uni_opr_o_temit = tok_valid && (sel_f ? head.f_uni_opr : head.t_uni_opr);
  assign tok_gen_o_temit     = tok_valid ? head.gen : '0;
  assign tok_data_o_temit    = tok_valid ? head.data : '0;
  assign tok_last_o_temit    = tok_last;
  assign term_o_temit        = term_q;
  assign busy_o_temit        = (fifo_count != '0);
  assign tok_cnt_o_temit     = tok_cnt_q;

endmodule

// File: tb/tb_token_emitter.sv
// Directed self-checking bench for token_emitter: reset state, single
// token, copy, copy with null false path, null path, terminate,
// backpressure with full FIFO, and reset in the middle of a copy.
module tb_token_emitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic        cond;
  logic        cp;
  logic        terminate;
  logic [11:0] gen;
  logic [15:0] t_node;
  logic [15:0] f_node;
  logic        t_lr;
  logic        f_lr;
  logic        t_uni;
  logic        f_uni;
  logic        tok_valid;
  logic        tok_ready;
  logic [15:0] tok_node;
  logic [11:0] tok_gen;
  logic [31:0] tok_data;
  logic        tok_lr;
  logic        tok_uni;
  logic        tok_last;
  logic        term;
  logic        busy;
  logic [15:0] tok_cnt;

  int checks   = 0;
  int failures = 0;

  token_emitter dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid_i_temit       (in_valid),
    .in_ready_o_temit       (in_ready),
    .data_i_temit           (data),
    .cond_i_temit           (cond),
    .cp_i_temit             (cp),
    .terminate_i_temit      (terminate),
    .gen_i_temit            (gen),
    .t_next_node_i_temit    (t_node),
    .f_next_node_i_temit    (f_node),
    .t_next_lr_i_temit      (t_lr),
    .f_next_lr_i_temit      (f_lr),
    .t_next_uni_opr_i_temit (t_uni),
    .f_next_uni_opr_i_temit (f_uni),
    .tok_valid_o_temit      (tok_valid),
    .tok_ready_i_temit      (tok_ready),
    .tok_node_o_temit       (tok_node),
    .tok_gen_o_temit        (tok_gen),
    .tok_data_o_temit       (tok_data),
    .tok_lr_o_temit         (tok_lr),
    .tok_uni_opr_o_temit    (tok_uni),
    .tok_last_o_temit       (tok_last),
    .term_o_temit           (term),
    .busy_o_temit           (busy),
    .tok_cnt_o_temit        (tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic [31:0] d, input logic [11:0] g,
                         input logic c, input logic p, input logic tm,
                         input logic [15:0] tn, input logic [15:0] fn,
                         input logic tl, input logic fl,
                         input logic tu, input logic fu);
    data      = d;
    gen       = g;
    cond      = c;
    cp        = p;
    terminate = tm;
    t_node    = tn;
    f_node    = fn;
    t_lr      = tl;
    f_lr      = fl;
    t_uni     = tu;
    f_uni     = fu;
    in_valid  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst       = 1'b1;
    tok_ready = 1'b1;
    set_res(32'h0, 12'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tok_valid", tok_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_tok_valid", tok_valid, 0);
    chk("post_rst_term", term, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt", tok_cnt, 0);
    chk("post_rst_node", tok_node, 0);
    chk("post_rst_data", tok_data, 0);
    chk("post_rst_last", tok_last, 0);

    // Single result on the true path
    set_res(32'hDEADBEEF, 12'h05A, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("single_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("single_valid", tok_valid, 1);
    chk("single_node", tok_node, 16'h0012);
    chk("single_data", tok_data, 32'hDEADBEEF);
    chk("single_gen", tok_gen, 12'h05A);
    chk("single_last", tok_last, 1);
    chk("single_lr", tok_lr, 1);
    chk("single_uni", tok_uni, 0);
    chk("single_busy", busy, 1);
    chk("single_cnt_pre", tok_cnt, 0);
    tick();
    chk("single_done_valid", tok_valid, 0);
    chk("single_done_cnt", tok_cnt, 1);
    chk("single_done_busy", busy, 0);

    // Copy to both destinations (cond ignored)
    set_res(32'h00001111, 12'h001, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0006, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("copy_t_valid", tok_valid, 1);
    chk("copy_t_node", tok_node, 16'h0005);
    chk("copy_t_last", tok_last, 0);
    chk("copy_t_lr", tok_lr, 0);
    chk("copy_t_uni", tok_uni, 1);
    tick();
    chk("copy_f_valid", tok_valid, 1);
    chk("copy_f_node", tok_node, 16'h0006);
    chk("copy_f_last", tok_last, 1);
    chk("copy_f_lr", tok_lr, 1);
    chk("copy_f_uni", tok_uni, 0);
    chk("copy_f_data", tok_data, 32'h00001111);
    chk("copy_f_cnt", tok_cnt, 2);
    tick();
    chk("copy_done_valid", tok_valid, 0);
    chk("copy_done_cnt", tok_cnt, 3);

    // Copy with null false destination
    set_res(32'h00002222, 12'h002, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("cpnull_node", tok_node, 16'h0005);
    chk("cpnull_last", tok_last, 1);
    tick();
    chk("cpnull_done_valid", tok_valid, 0);
    chk("cpnull_done_cnt", tok_cnt, 4);
    chk("cpnull_done_busy", busy, 0);

    // Selected path is null: silent pop
    set_res(32'h00003333, 12'h003, 1'b0, 1'b0, 1'b0, 16'h0077, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("null_valid", tok_valid, 0);
    chk("null_busy", busy, 1);
    tick();
    chk("null_done_busy", busy, 0);
    chk("null_done_valid", tok_valid, 0);
    chk("null_done_cnt", tok_cnt, 4);

    // Terminate
    set_res(32'h00004444, 12'h004, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("term_valid0", tok_valid, 0);
    chk("term_busy0", busy, 1);
    chk("term_pulse0", term, 0);
    tick();
    chk("term_pulse1", term, 1);
    chk("term_busy1", busy, 0);
    chk("term_valid1", tok_valid, 0);
    tick();
    chk("term_pulse2", term, 0);
    chk("term_cnt", tok_cnt, 4);

    // Backpressure: fill the FIFO with ready low
    tok_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_res(32'hA0000000 | 32'(i), 12'h0A0, 1'b1, 1'b0, 1'b0, 16'(16'h0010 + i), 16'h0099,
              1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_accept_ready", in_ready, 1);
      tick();
    end
    set_res(32'hA0000004, 12'h0A0, 1'b1, 1'b0, 1'b0, 16'h0014, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("bp_full_in_ready", in_ready, 0);
      chk("bp_hold_valid", tok_valid, 1);
      chk("bp_hold_node", tok_node, 16'h0010);
      chk("bp_hold_data", tok_data, 32'hA0000000);
      chk("bp_hold_last", tok_last, 1);
      tick();
    end
    in_valid  = 1'b0;
    tok_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", tok_valid, 1);
      chk("bp_drain_node", tok_node, 64'(16'h0010 + i));
      chk("bp_drain_data", tok_data, 64'(32'hA0000000 | 32'(i)));
      tick();
    end
    chk("bp_done_valid", tok_valid, 0);
    chk("bp_done_cnt", tok_cnt, 8);
    chk("bp_done_busy", busy, 0);
    chk("bp_done_in_ready", in_ready, 1);

    // Reset between the two tokens of a copy
    set_res(32'h00005555, 12'h005, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rcopy_t_node", tok_node, 16'h0021);
    chk("rcopy_t_last", tok_last, 0);
    tick();
    chk("rcopy_f_node", tok_node, 16'h0022);
    chk("rcopy_cnt", tok_cnt, 9);
    rst = 1'b1;
    #1;
    chk("rcopy_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    chk("rcopy_valid", tok_valid, 0);
    chk("rcopy_busy", busy, 0);
    chk("rcopy_cnt_clr", tok_cnt, 0);
    chk("rcopy_node", tok_node, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rcopy_no_second", tok_valid, 0);
    end
    chk("rcopy_cnt_final", tok_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
